// File: rtl/wave_scope_pkg.sv
// Shared constants for the capture-buffer display path.
//   - Capture geometry: 1024 samples, each mapped onto a 256-row window.
//   - Default colours for the trace, the graticule and the background.
//   - Lock FSM state encoding, which the capture side also sees.
//   - Video coordinate width.
// sample_row() maps an 8-bit sample to its screen row. 0 lands on the bottom
// row of the window and 255 on the top row.
package wave_scope_pkg;

  localparam int unsigned CoordW     = 12;
  localparam int unsigned NumSamples = 1024;
  localparam int unsigned NumRows    = 256;
  localparam int unsigned AddrW      = 10;
  localparam int unsigned SampleW    = 8;
  localparam int unsigned RowW       = 8;

  typedef logic [23:0] rgb_t;

  localparam rgb_t CTraceDef = 24'hFFFF00;
  localparam rgb_t CGridDef  = 24'h404040;
  localparam rgb_t CBgDef    = 24'h000000;

  localparam int unsigned StateW = 2;
  localparam logic [StateW-1:0] S_IDLE = 2'd0;
  localparam logic [StateW-1:0] S_LOCK = 2'd1;
  localparam logic [StateW-1:0] S_ACK  = 2'd2;

  function automatic logic [CoordW-1:0] sample_row(input logic [CoordW-1:0] y_top,
                                                   input logic [SampleW-1:0] s);
    return y_top + CoordW'(NumRows - 1) - CoordW'(s);
  endfunction

endpackage

// File: rtl/wave_trace_render_if.sv
// Bundles the signals between the trace renderer and its environment.
//   pixel_xpos/pixel_ypos : raster position from the video driver
//   trace_en              : draw the trace (1) or the graticule only (0)
//   cap_done              : the capture buffer holds a complete capture
//   rd_addr/rd_data       : capture RAM read port
//   buf_lock/cap_ack      : frame-level buffer lock handshake to the capture side
//   pixel_data            : RGB888 out to the display path
// The master modport is the renderer. The slave modport is the surrounding
// video, RAM and capture logic.
interface wave_trace_render_if;

  logic [wave_scope_pkg::CoordW-1:0]  pixel_xpos;
  logic [wave_scope_pkg::CoordW-1:0]  pixel_ypos;
  logic                               trace_en;
  logic                               cap_done;
  logic [wave_scope_pkg::AddrW-1:0]   rd_addr;
  logic [wave_scope_pkg::SampleW-1:0] rd_data;
  logic                               buf_lock;
  logic                               cap_ack;
  wave_scope_pkg::rgb_t               pixel_data;

  modport master (
    input  pixel_xpos,
    input  pixel_ypos,
    input  trace_en,
    input  cap_done,
    input  rd_data,
    output rd_addr,
    output buf_lock,
    output cap_ack,
    output pixel_data
  );

  modport slave (
    output pixel_xpos,
    output pixel_ypos,
    output trace_en,
    output cap_done,
    output rd_data,
    input  rd_addr,
    input  buf_lock,
    input  cap_ack,
    input  pixel_data
  );

endinterface

// File: rtl/trace_span_cmp.sv
// Decides whether the current pixel row lies on the trace segment of one column.
// The segment joins the previous column's sample to this column's sample.
// Ports:
//   clk_i, sys_rst_ni : clock and synchronous active-low reset
//   sample_i          : RAM read data, which is the sample of the column now on pixel_xpos
//   first_col_i       : column 0 of the window; no segment back to the previous line
//   ypos_i            : current pixel row
//   hit_o             : the row lies within [lo, hi] of this column's segment
module trace_span_cmp
  import wave_scope_pkg::*;
#(
  parameter logic [CoordW-1:0] Y_TOP = 12'd200
) (
  input  logic               clk_i,
  input  logic               sys_rst_ni,
  input  logic [SampleW-1:0] sample_i,
  input  logic               first_col_i,
  input  logic [CoordW-1:0]  ypos_i,
  output logic               hit_o
);

  // last_q captures the RAM output every cycle. The raster advances one column
  // per cycle, so when this column is compared, last_q holds the previous
  // column's sample.
  logic [SampleW-1:0] last_q, last_d;
  logic [SampleW-1:0] prev_s;
  logic [CoordW-1:0]  sy_cur, sy_prev, lo, hi;

  always_comb begin
    last_d  = sample_i;
    prev_s  = first_col_i ? sample_i : last_q;
    sy_cur  = sample_row(Y_TOP, sample_i);
    sy_prev = sample_row(Y_TOP, prev_s);
    if (sy_cur <= sy_prev) begin
      lo = sy_cur;
      hi = sy_prev;
    end else begin
      lo = sy_prev;
      hi = sy_cur;
    end
    hit_o = (ypos_i >= lo) && (ypos_i <= hi);
  end

  always_ff @(posedge clk_i) begin
    if (!sys_rst_ni) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wave_trace_render.sv
// Reads the capture RAM back in raster order and renders it as pixels.
// Each pixel gets a graticule, a border and a connected trace, with one sample
// per column. The block also holds a frame-level lock on the buffer, so the
// capture side cannot overwrite the buffer while it is on screen.
// Ports:
//   pixel_clk : the only clock
//   sys_rst_n : synchronous active-low reset
//   bus       : master side of wave_trace_render_if. It carries the raster
//               position, the RAM read port, the lock handshake and pixel_data.
// Pixel data is registered. Coordinates presented at cycle t give that
// pixel's colour at t+1.
module wave_trace_render
  import wave_scope_pkg::*;
#(
  parameter logic [CoordW-1:0] X_START   = 12'd9,
  parameter logic [CoordW-1:0] Y_TOP     = 12'd200,
  parameter int unsigned       RD_LAT    = 2,   // 1..4
  parameter int unsigned       GRID_STEP = 32,  // power of 2
  parameter rgb_t              C_TRACE   = CTraceDef,
  parameter rgb_t              C_GRID    = CGridDef,
  parameter rgb_t              C_BG      = CBgDef
) (
  input logic                 pixel_clk,
  input logic                 sys_rst_n,
  wave_trace_render_if.master bus
);

  localparam logic [AddrW-1:0]  XStartLo = X_START[AddrW-1:0];
  localparam logic [AddrW-1:0]  RdLatA   = AddrW'(RD_LAT);
  localparam logic [AddrW-1:0]  ColMask  = AddrW'(GRID_STEP - 1);
  localparam logic [RowW-1:0]   RowMask  = RowW'(GRID_STEP - 1);
  localparam logic [AddrW-1:0]  ColLast  = AddrW'(NumSamples - 1);
  localparam logic [RowW-1:0]   RowLast  = RowW'(NumRows - 1);
  localparam logic [CoordW-1:0] XLast    = X_START + CoordW'(NumSamples - 1);
  localparam logic [CoordW-1:0] YLast    = Y_TOP + CoordW'(NumRows - 1);

  logic [CoordW-1:0] x, y;
  logic [CoordW-1:0] col_full, row_full;
  logic [AddrW-1:0]  col;
  logic [RowW-1:0]   row;
  logic              in_win, frame_start, last_px;
  logic              span_hit, on_border, on_grat;

  logic [StateW-1:0] state_q, state_d;
  logic              buf_lock_q, buf_lock_d;
  logic              cap_ack_q, cap_ack_d;
  logic              lock_valid_q, lock_valid_d;
  rgb_t              pixel_q, pixel_d;

  assign x        = bus.pixel_xpos;
  assign y        = bus.pixel_ypos;
  assign col_full = x - X_START;
  assign row_full = y - Y_TOP;
  assign col      = col_full[AddrW-1:0];
  assign row      = row_full[RowW-1:0];

  assign in_win = (x >= X_START) && (col_full < CoordW'(NumSamples)) &&
                  (y >= Y_TOP) && (row_full < CoordW'(NumRows));

  assign frame_start = (x == '0) && (y == '0);
  assign last_px     = (x == XLast) && (y == YLast);

  // Prefetch RD_LAT columns ahead, so the sample for column x is on rd_data
  // while pixel_xpos == x. Outside the window the address wraps harmlessly.
  assign bus.rd_addr = sys_rst_n ? (x[AddrW-1:0] - XStartLo + RdLatA) : '0;

  trace_span_cmp #(
    .Y_TOP (Y_TOP)
  ) u_span (
    .clk_i       (pixel_clk),
    .sys_rst_ni  (sys_rst_n),
    .sample_i    (bus.rd_data),
    .first_col_i (col == '0),
    .ypos_i      (y),
    .hit_o       (span_hit)
  );

  assign on_border = (col == '0) || (col == ColLast) || (row == '0) || (row == RowLast);

  // Both graticule directions are dotted: vertical lines use even rows,
  // horizontal lines use even columns.
  assign on_grat = (((col & ColMask) == '0) && !y[0]) ||
                   (((row & RowMask) == '0) && !col[0]);

  always_comb begin
    state_d      = state_q;
    buf_lock_d   = buf_lock_q;
    cap_ack_d    = 1'b0;
    lock_valid_d = lock_valid_q;
    unique case (state_q)
      S_IDLE: begin
        // With no new capture the previous lock_valid is kept, so the last
        // trace is redrawn.
        if (frame_start && bus.cap_done) begin
          state_d      = S_LOCK;
          buf_lock_d   = 1'b1;
          lock_valid_d = 1'b1;
        end
      end
      S_LOCK: begin
        if (last_px) begin
          state_d    = S_ACK;
          buf_lock_d = 1'b0;
          cap_ack_d  = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        buf_lock_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pixel_d = C_BG;
    if (!in_win) begin
      pixel_d = C_BG;
    end else if (bus.trace_en && lock_valid_q && span_hit) begin
      pixel_d = C_TRACE;
    end else if (on_border || on_grat) begin
      pixel_d = C_GRID;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      buf_lock_q   <= 1'b0;
      cap_ack_q    <= 1'b0;
      lock_valid_q <= 1'b0;
      pixel_q      <= C_BG;
    end else begin
      state_q      <= state_d;
      buf_lock_q   <= buf_lock_d;
      cap_ack_q    <= cap_ack_d;
      lock_valid_q <= lock_valid_d;
      pixel_q      <= pixel_d;
    end
  end

  assign bus.buf_lock   = buf_lock_q;
  assign bus.cap_ack    = cap_ack_q;
  assign bus.pixel_data = pixel_q;

endmodule
